// File: rtl/sprite_compositor_pkg.sv
// Shared constants and helpers for the sprite compositor: default widths,
// register-word field layout and the lowest-index priority encoder.
package sprite_compositor_pkg;

  localparam int unsigned N_OBJ_DEF   = 9;
  localparam int unsigned COORD_W_DEF = 10;
  localparam int unsigned ID_W_DEF    = $clog2(N_OBJ_DEF);

  localparam int unsigned OBJ_PLAYER  = 0;

  localparam int unsigned REG_WORD_W  = 32;
  localparam int unsigned REG_X_LSB   = 0;
  localparam int unsigned REG_Y_LSB   = 0;

  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned PRIO_MAX    = 32;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [7:0] prio_lowest(input logic [PRIO_MAX-1:0] vec);
    logic [7:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PRIO_MAX; i++) begin
      if (vec[i] && !found) begin
        idx   = 8'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-in / hit-out stream between the VGA timing path and the compositor.
interface sprite_compositor_if
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned ID_W    = ID_W_DEF
);

  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               out_valid;
  logic               out_hit;
  logic [ID_W-1:0]    out_id;

  modport master (
    output pix_valid, pix_x, pix_y,
    input  out_valid, out_hit, out_id
  );

  modport slave (
    input  pix_valid, pix_x, pix_y,
    output out_valid, out_hit, out_id
  );

endinterface

// File: rtl/sprite_compositor_obj_rect_hit.sv
// Combinational point-in-rectangle test for one object; edges are summed one
// bit wider than the coordinate so objects past the screen edge never wrap.
module obj_rect_hit
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic               en,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               hit
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, ox} + {1'b0, w};
  assign y_end = {1'b0, oy} + {1'b0, h};

  assign hit = en
            && (px >= ox) && ({1'b0, px} < x_end)
            && (py >= oy) && ({1'b0, py} < y_end);

endmodule

// File: rtl/sprite_compositor.sv
// Frame-snapshotted object hit compositor: two-stage pixel pipeline reporting
// the highest-priority covering object, plus a sticky player collision flag.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned N_OBJ   = N_OBJ_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned ID_W    = $clog2(N_OBJ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic [N_OBJ*REG_WORD_W-1:0]    obj_x,
  input  logic [N_OBJ*REG_WORD_W-1:0]    obj_y,
  input  logic [N_OBJ*COORD_W-1:0]       obj_w,
  input  logic [N_OBJ*COORD_W-1:0]       obj_h,
  input  logic [N_OBJ-1:0]               obj_en,
  sprite_compositor_if.slave             pix,
  input  logic                           collide_clear,
  output logic                           collide_flag,
  output logic [FRAME_CNT_W-1:0]         frame_count
);

  logic [COORD_W-1:0] act_x [N_OBJ];
  logic [COORD_W-1:0] act_y [N_OBJ];
  logic [COORD_W-1:0] act_w [N_OBJ];
  logic [COORD_W-1:0] act_h [N_OBJ];
  logic [N_OBJ-1:0]   act_en;

  logic [N_OBJ-1:0]   hit_comb;
  logic [N_OBJ-1:0]   hit_s1;
  logic [N_OBJ-1:0]   hit_others;
  logic               valid_s1;

  logic               out_valid_r;
  logic               out_hit_r;
  logic [ID_W-1:0]    out_id_r;

  // Only the low COORD_W bits of each register word carry a coordinate.
  logic unused_reg_bits;
  assign unused_reg_bits = ^{obj_x, obj_y};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        act_x[i] <= '0;
        act_y[i] <= '0;
        act_w[i] <= '0;
        act_h[i] <= '0;
      end
      act_en <= '0;
    end else if (frame_start) begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        act_x[i] <= obj_x[REG_WORD_W*i + REG_X_LSB +: COORD_W];
        act_y[i] <= obj_y[REG_WORD_W*i + REG_Y_LSB +: COORD_W];
        act_w[i] <= obj_w[COORD_W*i +: COORD_W];
        act_h[i] <= obj_h[COORD_W*i +: COORD_W];
      end
      act_en <= obj_en;
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    obj_rect_hit #(.COORD_W(COORD_W)) u_hit (
      .en (act_en[g]),
      .ox (act_x[g]),
      .oy (act_y[g]),
      .w  (act_w[g]),
      .h  (act_h[g]),
      .px (pix.pix_x),
      .py (pix.pix_y),
      .hit(hit_comb[g])
    );
  end

  always_comb begin
    hit_others             = hit_s1;
    hit_others[OBJ_PLAYER] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_s1      <= '0;
      valid_s1    <= 1'b0;
      out_valid_r <= 1'b0;
      out_hit_r   <= 1'b0;
      out_id_r    <= '0;
    end else begin
      hit_s1      <= hit_comb;
      valid_s1    <= pix.pix_valid;
      out_valid_r <= valid_s1;
      out_hit_r   <= valid_s1 & (|hit_s1);
      out_id_r    <= valid_s1 ? ID_W'(prio_lowest(PRIO_MAX'(hit_s1))) : '0;
    end
  end

  // Set takes precedence over a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      collide_flag <= 1'b0;
    end else if (valid_s1 && hit_s1[OBJ_PLAYER] && (|hit_others)) begin
      collide_flag <= 1'b1;
    end else if (collide_clear) begin
      collide_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  assign pix.out_valid = out_valid_r;
  assign pix.out_hit   = out_hit_r;
  assign pix.out_id    = out_id_r;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized bench for sprite_compositor against a rectangle model.
module tb_sprite_compositor;
  import sprite_compositor_pkg::*;

  localparam int N  = 9;
  localparam int CW = 10;
  localparam int IW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_start = 1'b0;
  logic              collide_clear = 1'b0;
  logic [N*32-1:0]   obj_x = '0;
  logic [N*32-1:0]   obj_y = '0;
  logic [N*CW-1:0]   obj_w = '0;
  logic [N*CW-1:0]   obj_h = '0;
  logic [N-1:0]      obj_en = '0;
  logic              collide_flag;
  logic [15:0]       frame_count;

  sprite_compositor_if #(.COORD_W(CW), .ID_W(IW)) pix ();

  sprite_compositor #(.N_OBJ(N), .COORD_W(CW), .ID_W(IW)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_w        (obj_w),
    .obj_h        (obj_h),
    .obj_en       (obj_en),
    .pix          (pix.slave),
    .collide_clear(collide_clear),
    .collide_flag (collide_flag),
    .frame_count  (frame_count)
  );

  always #5 clock = ~clock;

  // Reference model: active rectangles and expected pipeline contents.
  int m_x [N];
  int m_y [N];
  int m_w [N];
  int m_h [N];
  bit m_en [N];
  bit s1_v, s1_col;
  int s1_id;
  bit e_valid, e_hit, e_flag;
  int e_id, e_fc;

  int checks = 0;
  int errors = 0;
  bit auto_chk = 1'b1;

  function automatic bit covers(int i, int px, int py);
    return m_en[i] && px >= m_x[i] && px < m_x[i] + m_w[i]
                   && py >= m_y[i] && py < m_y[i] + m_h[i];
  endfunction

  function automatic int first_cover(int px, int py);
    for (int i = 0; i < N; i++) if (covers(i, px, py)) return i;
    return -1;
  endfunction

  function automatic bit collides(int px, int py);
    bit other = 1'b0;
    for (int i = 1; i < N; i++) if (covers(i, px, py)) other = 1'b1;
    return covers(0, px, py) && other;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0; m_en[i] = 1'b0;
    end
    s1_v = 1'b0; s1_col = 1'b0; s1_id = -1;
    e_valid = 1'b0; e_hit = 1'b0; e_id = 0; e_flag = 1'b0; e_fc = 0;
  endtask

  task automatic check_all();
    chk("out_valid", 32'(pix.out_valid), 32'(e_valid));
    chk("out_hit", 32'(pix.out_hit), 32'(e_hit));
    chk("out_id", 32'(pix.out_id), e_id);
    chk("collide_flag", 32'(collide_flag), 32'(e_flag));
    chk("frame_count", 32'(frame_count), e_fc);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (s1_v && s1_col) e_flag = 1'b1;
      else if (collide_clear) e_flag = 1'b0;
      e_valid = s1_v;
      e_hit   = s1_v && (s1_id >= 0);
      e_id    = e_hit ? s1_id : 0;
      s1_v    = pix.pix_valid;
      s1_id   = first_cover(int'(pix.pix_x), int'(pix.pix_y));
      s1_col  = collides(int'(pix.pix_x), int'(pix.pix_y));
      if (frame_start) begin
        for (int i = 0; i < N; i++) begin
          m_x[i]  = int'(obj_x[32*i +: CW]);
          m_y[i]  = int'(obj_y[32*i +: CW]);
          m_w[i]  = int'(obj_w[CW*i +: CW]);
          m_h[i]  = int'(obj_h[CW*i +: CW]);
          m_en[i] = obj_en[i];
        end
        e_fc = (e_fc + 1) % 65536;
      end
    end
    #1;
    if (auto_chk) check_all();
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h, input bit en);
    obj_x[32*i +: 32] = {22'($urandom), CW'(x)};
    obj_y[32*i +: 32] = {22'($urandom), CW'(y)};
    obj_w[CW*i +: CW] = CW'(w);
    obj_h[CW*i +: CW] = CW'(h);
    obj_en[i]         = en;
  endtask

  task automatic clear_objs();
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic pixel(input bit v, input int x, input int y);
    pix.pix_valid = v;
    pix.pix_x     = CW'(x);
    pix.pix_y     = CW'(y);
    tick();
  endtask

  task automatic idle();
    pixel(1'b0, 0, 0);
  endtask

  task automatic snapshot();
    frame_start = 1'b1;
    idle();
    frame_start = 1'b0;
  endtask

  int fc_before;
  int j, px, py;

  initial begin
    pix.pix_valid = 1'b0;
    pix.pix_x     = '0;
    pix.pix_y     = '0;
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 10, 10, 1'b1);
    model_reset();

    #2;
    chk("rst_valid", 32'(pix.out_valid), 0);
    chk("rst_hit", 32'(pix.out_hit), 0);
    chk("rst_id", 32'(pix.out_id), 0);
    chk("rst_flag", 32'(collide_flag), 0);
    chk("rst_fc", 32'(frame_count), 0);
    tick();
    reset = 1'b0;

    // Shadow objects enabled but never snapshotted.
    pixel(1'b1, 5, 5);
    idle();
    chk("noshot_valid", 32'(pix.out_valid), 1);
    chk("noshot_hit", 32'(pix.out_hit), 0);
    chk("noshot_id", 32'(pix.out_id), 0);

    // Object 3 edges.
    clear_objs();
    set_obj(3, 100, 50, 20, 30, 1'b1);
    snapshot();
    pixel(1'b1, 100, 50);
    pixel(1'b1, 119, 79);
    chk("o3_tl_hit", 32'(pix.out_hit), 1);
    chk("o3_tl_id", 32'(pix.out_id), 3);
    pixel(1'b1, 120, 79);
    chk("o3_br_id", 32'(pix.out_id), 3);
    idle();
    chk("o3_out_hit", 32'(pix.out_hit), 0);
    chk("o3_out_valid", 32'(pix.out_valid), 1);

    // Player/obstacle collision, set-over-clear, then clear.
    clear_objs();
    set_obj(0, 200, 200, 10, 10, 1'b1);
    set_obj(2, 195, 195, 20, 20, 1'b1);
    snapshot();
    pixel(1'b1, 200, 200);
    pixel(1'b1, 201, 201);
    chk("col_id", 32'(pix.out_id), 0);
    chk("col_flag", 32'(collide_flag), 1);
    collide_clear = 1'b1;
    idle();
    chk("col_set_wins", 32'(collide_flag), 1);
    idle();
    chk("col_cleared", 32'(collide_flag), 0);
    collide_clear = 1'b0;

    // Shadow change without snapshot keeps the old position.
    clear_objs();
    set_obj(1, 10, 100, 10, 10, 1'b1);
    snapshot();
    set_obj(1, 300, 100, 10, 10, 1'b1);
    pixel(1'b1, 10, 100);
    idle();
    chk("old_pos_hit", 32'(pix.out_hit), 1);
    chk("old_pos_id", 32'(pix.out_id), 1);
    snapshot();
    pixel(1'b1, 10, 100);
    pixel(1'b1, 300, 100);
    chk("new_pos_old_miss", 32'(pix.out_hit), 0);
    idle();
    chk("new_pos_hit", 32'(pix.out_hit), 1);
    chk("new_pos_id", 32'(pix.out_id), 1);

    // Zero width, right-edge clipping, and no wrap past the coordinate range.
    clear_objs();
    set_obj(4, 50, 50, 0, 10, 1'b1);
    set_obj(5, 630, 400, 20, 10, 1'b1);
    set_obj(6, 1020, 400, 20, 10, 1'b1);
    snapshot();
    pixel(1'b1, 50, 55);
    pixel(1'b1, 639, 405);
    chk("zero_w_miss", 32'(pix.out_hit), 0);
    pixel(1'b1, 5, 405);
    chk("edge_hit_id", 32'(pix.out_id), 5);
    pixel(1'b1, 1023, 405);
    chk("no_wrap_miss", 32'(pix.out_hit), 0);
    idle();
    chk("top_coord_id", 32'(pix.out_id), 6);

    // frame_count wraps after 65536 pulses.
    fc_before = int'(frame_count);
    auto_chk = 1'b0;
    frame_start = 1'b1;
    repeat (65536) tick();
    frame_start = 1'b0;
    auto_chk = 1'b1;
    idle();
    chk("fc_wrap", 32'(frame_count), 32'(fc_before));

    // Randomized objects, pixels, snapshots and clears.
    repeat (1500) begin
      frame_start = ($urandom_range(0, 49) == 0);
      if (frame_start) begin
        for (int i = 0; i < N; i++)
          set_obj(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 120),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 120),
                  $urandom_range(0, 3) != 0);
      end
      collide_clear = ($urandom_range(0, 7) == 0);
      j  = $urandom_range(0, N - 1);
      px = int'(obj_x[32*j +: CW]) + $urandom_range(0, 130) - 5;
      py = int'(obj_y[32*j +: CW]) + $urandom_range(0, 130) - 5;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      pixel($urandom_range(0, 3) != 0, px, py);
    end
    frame_start   = 1'b0;
    collide_clear = 1'b0;

    // Asynchronous reset with colliding pixels in flight.
    clear_objs();
    set_obj(0, 50, 50, 10, 10, 1'b1);
    set_obj(1, 50, 50, 10, 10, 1'b1);
    snapshot();
    pixel(1'b1, 55, 55);
    pixel(1'b1, 55, 55);
    pixel(1'b1, 55, 55);
    chk("pre_rst_flag", 32'(collide_flag), 1);
    chk("pre_rst_valid", 32'(pix.out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(pix.out_valid), 0);
    chk("arst_flag", 32'(collide_flag), 0);
    chk("arst_hit", 32'(pix.out_hit), 0);
    chk("arst_fc", 32'(frame_count), 0);
    model_reset();
    tick();
    reset = 1'b0;
    pixel(1'b1, 55, 55);
    pixel(1'b1, 55, 55);
    chk("post_rst_valid", 32'(pix.out_valid), 1);
    chk("post_rst_hit", 32'(pix.out_hit), 0);
    chk("post_rst_flag", 32'(collide_flag), 0);
    snapshot();
    pixel(1'b1, 55, 55);
    idle();
    chk("post_shot_hit", 32'(pix.out_hit), 1);
    chk("post_shot_flag", 32'(collide_flag), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised object-hit compositor between the processor register file and the VGA pixel path. It replaces the fixed bird-plus-eight-pipes wiring with N_OBJ generic rectangular objects, each with position, size and enable. All object registers are snapshotted at frame start so a frame is never torn mid-scan. For every pixel coordinate it reports the highest-priority object covering that pixel. It also maintains a sticky bird-versus-obstacle collision flag that game software can poll and clear.

## Interface
- N_OBJ, 9, number of objects; index 0 is the player (bird) and has top priority.
- COORD_W, 10, coordinate width in bits (covers 640x480).
- ID_W, $clog2(N_OBJ), object index width.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank; loads the snapshot.
- obj_x  in  N_OBJ*32  packed register values; bits [COORD_W-1:0] of each word used, object i at [32*i +: 32].
- obj_y  in  N_OBJ*32  as obj_x.
- obj_w  in  N_OBJ*COORD_W  object widths.
- obj_h  in  N_OBJ*COORD_W  object heights.
- obj_en  in  N_OBJ  per-object enable.
- pix_valid  in  1  pixel coordinate valid.
- pix_x, pix_y  in  COORD_W  pixel coordinate.
- out_valid  out  1  pix_valid delayed 2 cycles.
- out_hit  out  1  some enabled object covers the pixel.
- out_id  out  ID_W  lowest-index covering object; 0 when out_hit=0.
- collide_flag  out  1  sticky: player and another object covered the same valid pixel.
- collide_clear  in  1  clears collide_flag.
- frame_count  out  16  number of frame_start pulses, wrapping.

## Operation
- Snapshot: on a clock edge with frame_start=1, all obj_x/obj_y/obj_w/obj_h/obj_en are copied into active registers. A pixel sampled on that same edge uses the old active set.
- Hit test per object i: en_i && x >= ox_i && x < ox_i+w_i && y >= oy_i && y < oy_i+h_i.
  - Sums are computed at COORD_W+1 bits so there is no wrap-around.
  - A width or height of 0 never hits.
  - An object extending past the screen edge is clipped naturally.
- Stage 1 registers the N_OBJ hit vector and valid.
- Stage 2 registers:
  - out_hit = OR of the hit vector.
  - out_id = priority-encoded lowest set bit.
  - out_valid.
- When the stage-1 valid is 0, stage 2 drives out_hit=0 and out_id=0.
- Collision: set on the edge that loads stage 2 when stage-1 valid=1 and hit[0]=1 and any hit[i>0]=1.
  - Cleared by collide_clear=1.
  - If set and clear occur in the same cycle, set wins (flag stays 1).
- frame_count increments on each frame_start; 0xFFFF wraps to 0x0000.
- Reset values: active registers 0 and all enables 0 (no hits until the first frame_start); pipeline valids 0; out_valid=0, out_hit=0, out_id=0, collide_flag=0, frame_count=0.
- Reset asserted mid-frame discards in-flight pixels immediately (asynchronous clear).
- The block has no backpressure: one pixel per cycle is accepted at all times.

## Timing
- Pixel input at edge t produces outputs valid after edge t+2 (latency 2, throughput 1 per cycle).
- collide_flag rises after the same edge that presents the colliding pixel on out_*.
- A snapshot taken at edge t affects pixels sampled at edge t+1 onward.
- frame_count updates one edge after frame_start is sampled.

## Structure
- Shared package holds:
  - default COORD_W and ID_W;
  - OBJ_PLAYER=0;
  - the 32-bit register-word field positions for x/y;
  - the frame_count width.
- Sub-module obj_rect_hit performs the combinational compare for one object and is instantiated N_OBJ times via generate.
- The priority encoder is a function in the package.

## Test plan
- Reset, then pix (5,5) valid with all objects enabled in the shadow inputs but no frame_start -> out_valid=1 at t+2, out_hit=0, out_id=0.
- Object 3 at x=100,y=50,w=20,h=30, frame_start, then pix (100,50), (119,79), (120,79) -> hits id 3, id 3, miss.
- Objects 0 and 2 overlapping at (200,200), pixel (200,200) -> out_id=0, collide_flag=1; collide_clear same cycle as a second colliding pixel -> flag stays 1; clear alone -> 0.
- Change obj_x of object 1 from 10 to 300 without frame_start -> pixel (10,y) still hits id 1; after frame_start it misses and (300,y) hits.
- Object with w=0 or obj_x=630,w=20 at pixel (639,y) -> no hit and hit respectively (no wrap); 65536 frame_start pulses -> frame_count returns to 0.
- Assert reset with valid pixels in flight -> out_valid and collide_flag drop to 0 immediately; no hits until the next frame_start.
